// File: rtl/shift_arbiter.sv
// ============================================================================
// Module   : shift_arbiter
// Brief    : Two-requester arbiter in front of an external combinational
//            shifter; IDLE -> CALC -> RESP per job. Define
//            SHIFT_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins),
//            otherwise contention is resolved round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_arbiter #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [AMT_W-1:0]  req0_amt_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [AMT_W-1:0]  req1_amt_i,
  output logic              req1_ready_o,
  output logic [DATA_W-1:0] sh_a_o,
  output logic [AMT_W-1:0]  sh_amt_o,
  input  logic [DATA_W-1:0] sh_y_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              resp_id_o,
  input  logic              resp_ready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sh_a_q;
  logic [AMT_W-1:0]    sh_amt_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic                resp_id_q;
  logic                resp_valid_q;
  logic                owner_q;
  logic                grant;
  logic                xfer;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
  assign grant = req0_valid_i ? 1'b0 : 1'b1;
`else
  logic last_id_q;

  // Under contention the requester that did not win last time goes next.
  assign grant = (req0_valid_i && req1_valid_i) ? ~last_id_q : req1_valid_i;
`endif

  assign req0_ready_o = (state_q == IDLE) && !reset_i && !grant && req0_valid_i;
  assign req1_ready_o = (state_q == IDLE) && !reset_i &&  grant && req1_valid_i;
  assign xfer         = req0_ready_o || req1_ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sh_a_q       <= '0;
      sh_amt_q     <= '0;
      owner_q      <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      resp_valid_q <= 1'b0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
      last_id_q    <= 1'b1;
`endif
    end else begin
      if (xfer) begin
        sh_a_q   <= grant ? req1_a_i   : req0_a_i;
        sh_amt_q <= grant ? req1_amt_i : req0_amt_i;
        owner_q  <= grant;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
        last_id_q <= grant;
`endif
      end
      if (state_q == CALC) begin
        resp_data_q  <= sh_y_i;
        resp_id_q    <= owner_q;
        resp_valid_q <= 1'b1;
      end else if ((state_q == RESP) && resp_ready_i) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign sh_a_o       = sh_a_q;
  assign sh_amt_o     = sh_amt_q;
  assign resp_data_o  = resp_data_q;
  assign resp_id_o    = resp_id_q;
  assign resp_valid_o = resp_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// ============================================================================
// Module   : tb_shift_arbiter
// Brief    : Directed self-checking bench for shift_arbiter with a
//            rotate-right shifter model attached.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_arbiter;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       req0_valid_i, req1_valid_i;
  logic [7:0] req0_a_i, req1_a_i;
  logic [2:0] req0_amt_i, req1_amt_i;
  logic       req0_ready_o, req1_ready_o;
  logic [7:0] sh_a_o;
  logic [2:0] sh_amt_o;
  logic [7:0] sh_y_i;
  logic       resp_valid_o;
  logic [7:0] resp_data_o;
  logic       resp_id_o;
  logic       resp_ready_i;
  logic [3:0] inv_amt;

  int checks = 0;
  int fails  = 0;

  always #5 clk_i = ~clk_i;

  assign inv_amt = 4'd8 - {1'b0, sh_amt_o};
  assign sh_y_i  = (sh_a_o >> sh_amt_o) | (sh_a_o << inv_amt);

  shift_arbiter #(.DATA_W(8), .AMT_W(3)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .req0_valid_i (req0_valid_i),
    .req0_a_i     (req0_a_i),
    .req0_amt_i   (req0_amt_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_a_i     (req1_a_i),
    .req1_amt_i   (req1_amt_i),
    .req1_ready_o (req1_ready_o),
    .sh_a_o       (sh_a_o),
    .sh_amt_o     (sh_amt_o),
    .sh_y_i       (sh_y_i),
    .resp_valid_o (resp_valid_o),
    .resp_data_o  (resp_data_o),
    .resp_id_o    (resp_id_o),
    .resp_ready_i (resp_ready_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    step();
  endtask

  initial begin
    reset_i      = 1'b1;
    req0_valid_i = 1'b1;
    req1_valid_i = 1'b1;
    req0_a_i     = 8'h00;
    req1_a_i     = 8'h00;
    req0_amt_i   = 3'd0;
    req1_amt_i   = 3'd0;
    resp_ready_i = 1'b0;
    #2;
    chk("rst_ready0", req0_ready_o, 1'b0);
    chk("rst_ready1", req1_ready_o, 1'b0);
    step();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    reset_i      = 1'b0;
    step();
    chk("rst_resp_valid", resp_valid_o, 1'b0);
    chk("rst_sh_a", sh_a_o, 8'h00);
    chk("rst_sh_amt", sh_amt_o, 3'd0);
    chk("rst_resp_data", resp_data_o, 8'h00);
    chk("rst_resp_id", resp_id_o, 1'b0);

    // Single job: 0xB1 rotated right by 3 gives 0x36.
    req0_valid_i = 1'b1;
    req0_a_i     = 8'hB1;
    req0_amt_i   = 3'd3;
    #1;
    chk("j1_ready0", req0_ready_o, 1'b1);
    chk("j1_ready1", req1_ready_o, 1'b0);
    step();
    req0_valid_i = 1'b0;
    chk("j1_calc_ready0", req0_ready_o, 1'b0);
    chk("j1_sh_a", sh_a_o, 8'hB1);
    chk("j1_sh_amt", sh_amt_o, 3'd3);
    chk("j1_calc_valid", resp_valid_o, 1'b0);
    step();
    chk("j1_resp_valid", resp_valid_o, 1'b1);
    chk("j1_resp_data", resp_data_o, 8'h36);
    chk("j1_resp_id", resp_id_o, 1'b0);
    resp_ready_i = 1'b1;
    step();
    chk("j1_done_valid", resp_valid_o, 1'b0);
    step();
    chk("idle_hold_sh_a", sh_a_o, 8'hB1);

    // Contention from reset: 0x01 ror 1 = 0x80, 0x80 ror 2 = 0x20.
    do_reset();
    req0_a_i     = 8'h01;
    req0_amt_i   = 3'd1;
    req1_a_i     = 8'h80;
    req1_amt_i   = 3'd2;
    req0_valid_i = 1'b1;
    req1_valid_i = 1'b1;
    resp_ready_i = 1'b1;
    #1;
    for (int j = 0; j < 4; j++) begin
      logic eg;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      eg = 1'b0;
`else
      eg = j[0];
`endif
      chk("rr_ready0", req0_ready_o, !eg);
      chk("rr_ready1", req1_ready_o, eg);
      step();
      chk("rr_calc_ready0", req0_ready_o, 1'b0);
      chk("rr_calc_ready1", req1_ready_o, 1'b0);
      step();
      chk("rr_resp_valid", resp_valid_o, 1'b1);
      chk("rr_resp_id", resp_id_o, eg);
      chk("rr_resp_data", resp_data_o, eg ? 8'h20 : 8'h80);
      step();
      chk("rr_idle_valid", resp_valid_o, 1'b0);
    end

    // Stall in RESP with req1 waiting: 0xC3 ror 4 = 0x3C, 0x0F ror 1 = 0x87.
    resp_ready_i = 1'b0;
    req0_a_i     = 8'hC3;
    req0_amt_i   = 3'd4;
    req1_a_i     = 8'h0F;
    req1_amt_i   = 3'd1;
    #1;
    chk("st_ready0", req0_ready_o, 1'b1);
    step();
    req0_valid_i = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("st_valid", resp_valid_o, 1'b1);
      chk("st_data", resp_data_o, 8'h3C);
      chk("st_id", resp_id_o, 1'b0);
      chk("st_ready1", req1_ready_o, 1'b0);
      step();
    end
    resp_ready_i = 1'b1;
    step();
    resp_ready_i = 1'b0;
    chk("st_release_valid", resp_valid_o, 1'b0);
    chk("st_release_ready1", req1_ready_o, 1'b1);
    step();
    req1_valid_i = 1'b0;
    chk("st_r1_sh_a", sh_a_o, 8'h0F);
    step();
    chk("st_r1_valid", resp_valid_o, 1'b1);
    chk("st_r1_data", resp_data_o, 8'h87);
    chk("st_r1_id", resp_id_o, 1'b1);
    resp_ready_i = 1'b1;
    step();

    // Reset pulsed mid-CALC drops the job.
    req0_valid_i = 1'b1;
    req0_a_i     = 8'hFF;
    req0_amt_i   = 3'd2;
    #1;
    step();
    req0_valid_i = 1'b0;
    chk("mr_calc_sh_a", sh_a_o, 8'hFF);
    #2;
    reset_i = 1'b1;
    #1;
    chk("mr_valid", resp_valid_o, 1'b0);
    chk("mr_sh_a", sh_a_o, 8'h00);
    chk("mr_sh_amt", sh_amt_o, 3'd0);
    chk("mr_data", resp_data_o, 8'h00);
    chk("mr_id", resp_id_o, 1'b0);
    #1;
    reset_i = 1'b0;
    step();
    step();
    chk("mr_no_resp", resp_valid_o, 1'b0);

    // amt = 0 passes the operand through.
    req0_valid_i = 1'b1;
    req0_a_i     = 8'h5A;
    req0_amt_i   = 3'd0;
    #1;
    chk("z_ready0", req0_ready_o, 1'b1);
    step();
    req0_valid_i = 1'b0;
    step();
    chk("z_valid", resp_valid_o, 1'b1);
    chk("z_data", resp_data_o, 8'h5A);
    chk("z_id", resp_id_o, 1'b0);
    step();
    chk("z_done", resp_valid_o, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width in bits; SHALL be a power of two, at least 2.
REQ-002 Parameter AMT_W, default 3, shift-amount width; SHALL equal log2(DATA_W).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester n presents a job.
REQ-006 req0_a / req1_a  input  DATA_W  operand of requester n.
REQ-007 req0_amt / req1_amt  input  AMT_W  shift amount of requester n.
REQ-008 req0_ready / req1_ready  output  1  job of requester n is accepted this cycle.
REQ-009 sh_a  output  DATA_W  registered operand driven to the shared combinational shifter.
REQ-010 sh_amt  output  AMT_W  registered amount driven to the shared shifter.
REQ-011 sh_y  input  DATA_W  shifter result, combinational from sh_a and sh_amt.
REQ-012 resp_valid  output  1  result available.
REQ-013 resp_data  output  DATA_W  registered shifter result.
REQ-014 resp_id  output  1  index of the requester that owns resp_data.
REQ-015 resp_ready  input  1  consumer accepts the result.

Function
REQ-016 FSM states SHALL be IDLE, CALC and RESP.
- IDLE: grant computed; ready asserted.
- CALC: shifter settles for one full cycle.
- RESP: result held until accepted.
REQ-017 In IDLE, reqN_ready SHALL be high only for the granted requester, and only when that requester's valid is high; both ready outputs SHALL be low in CALC and RESP.
REQ-018 A transfer SHALL occur on any edge where reqN_valid and reqN_ready are both high.
- On a transfer, sh_a, sh_amt and the owner id are loaded from the granted requester.
- State goes IDLE -> CALC.
REQ-019 In IDLE with no valid request, the state SHALL remain IDLE and sh_a/sh_amt SHALL hold their values.
REQ-020 CALC -> RESP unconditionally after one cycle.
- resp_data is loaded from sh_y and resp_id from the owner id.
- resp_valid rises.
REQ-021 Latency: a transfer at edge T SHALL give resp_valid high from edge T+2; peak throughput is one job per 3 cycles.
REQ-022 In RESP, resp_valid, resp_data and resp_id SHALL stay stable until an edge with resp_ready high; that edge clears resp_valid and returns to IDLE.
REQ-023 resp_ready sampled outside RESP SHALL be ignored.
REQ-024 Grant policy: a single valid requester is always granted.
- When both are valid, the grant goes per REQ-034.
REQ-025 Round-robin pointer last_id SHALL update only on a transfer, to the accepted id.
REQ-026 A requester deasserting valid before a transfer SHALL leave the FSM and last_id unchanged.

Reset
REQ-027 Reset SHALL act immediately, without waiting for a clock edge.
- FSM goes to IDLE.
- sh_a, sh_amt, resp_data = 0.
- resp_id = 0 and resp_valid = 0.
- last_id = 1, so that requester 0 wins the first contention.
REQ-028 Reset asserted in CALC or RESP SHALL discard the in-flight job with no response.
REQ-029 The ready outputs SHALL be low while reset is asserted.

Configuration
REQ-030 Macro SHIFT_ARB_FIXED_PRIO_EN SHALL select the contention policy at compile time.
REQ-031 With the macro defined: requester 0 SHALL always win contention, and last_id SHALL be unused.
REQ-032 Without the macro: both valid SHALL grant the requester not equal to last_id.
REQ-033 The macro SHALL NOT change ports, latency or reset values.
REQ-034 Contention means both reqN_valid high in IDLE; resolution is per REQ-031 / REQ-032.

Verification
REQ-035 Reset, then req0 valid with a=8'hB1, amt=3 (rotate-right shifter attached) -> req0_ready high at edge 0; resp_valid at edge 2; resp_data=8'h36, resp_id=0.
REQ-036 Both valid continuously, resp_ready tied high, round-robin build -> grants alternate 0,1,0,1, one job every 3 cycles.
REQ-037 Same stimulus, SHIFT_ARB_FIXED_PRIO_EN build -> every grant goes to requester 0 and req1_ready is never high.
REQ-038 resp_ready held low 5 cycles in RESP while req1 is valid -> resp_data and resp_id stable, req1_ready low throughout; on the resp_ready edge, IDLE is entered and req1 is accepted on the next edge.
REQ-039 Reset pulsed mid-CALC -> resp_valid stays 0, all outputs are at reset values immediately, and the next job runs normally.
REQ-040 amt=0 with a=8'h5A -> resp_data=8'h5A.
